vga_layer_sched: RTL

Frame-synchronous layer scheduler for the VGA output path. It sits between the timing/text generator (`controlador`) and the DAC pins. Each pixel it arbitrates four text-layer requests plus a background layer into one 3-bit colour. It owns the per-layer colour configuration, committing CPU/switch writes only at frame boundaries so colours never tear mid-frame. It also runs a frame counter that drives a blinking cursor layer.

---
 rtl/vga_layer_sched_if.sv | 31 +++
 rtl/vga_layer_sched.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/vga_layer_sched_if.sv
// Pixel, sync and configuration signals between the VGA timing path and the layer scheduler.
// The master drives timing, pixel requests and config writes; the slave returns the colour.
interface vga_layer_sched_if #(
   parameter int FRAME_W = 10
);
   logic               p_tick;
   logic               video_on;
   logic               vsync;
   logic [3:0]         text_on;
   logic               r;
   logic               g;
   logic               b;
   logic               cfg_we;
   logic [1:0]         cfg_addr;
   logic [2:0]         cfg_data;
   logic               cfg_ack;
   logic               cfg_pending;
   logic [2:0]         colores;
   logic [2:0]         layer_sel;
   logic [FRAME_W-1:0] frame_cnt;

   modport master (
      output p_tick, video_on, vsync, text_on, r, g, b, cfg_we, cfg_addr, cfg_data,
      input  cfg_ack, cfg_pending, colores, layer_sel, frame_cnt
   );

   modport slave (
      input  p_tick, video_on, vsync, text_on, r, g, b, cfg_we, cfg_addr, cfg_data,
      output cfg_ack, cfg_pending, colores, layer_sel, frame_cnt
   );
endinterface

// File: rtl/vga_layer_sched.sv
// Frame-synchronous text/background layer arbiter with shadowed colours and blink cursor.
// Latency: 1 clk pixel, colours commit one cycle after vsync edge; config writes never stall.
module vga_layer_sched #(
   parameter int BLINK_HALF = 30,
   parameter int FRAME_W    = 10
) (
   input  logic               clk,
   input  logic               rst,
   vga_layer_sched_if.slave   bus
);

   typedef enum logic [1:0] {
      SYNC_WAIT = 2'd0,
      RUN       = 2'd1,
      COMMIT    = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic               vsync_q;
   logic               vsync_rise;
   logic               commit;
   logic               blank;

   logic [2:0]         active [4];
   logic [2:0]         shadow [4];
   logic [2:0]         bg;
   logic [5:0]         blink_cnt;
   logic               blink_phase;
   logic [FRAME_W-1:0] frame_q;
   logic [2:0]         colores_q;
   logic [2:0]         layer_sel_q;
   logic               ack_q;
   logic               pending_q;

   logic [3:0]         elig;
   logic [2:0]         pix_c;
   logic [2:0]         sel_c;

   assign vsync_rise = bus.vsync & ~vsync_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= SYNC_WAIT;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      commit    = 1'b0;
      blank     = 1'b0;
      case (state)
         SYNC_WAIT: begin
            blank = 1'b1;
            if (vsync_rise) state_nxt = COMMIT;
         end
         RUN: begin
            if (vsync_rise) state_nxt = COMMIT;
         end
         COMMIT: begin
            commit    = 1'b1;
            state_nxt = RUN;
         end
         default: state_nxt = SYNC_WAIT;
      endcase
   end

   // Cursor layer only competes during the visible half of the blink period.
   assign elig = bus.text_on & {blink_phase, 3'b111};

   always_comb begin
      pix_c = bg;
      sel_c = 3'd4;
      if (!bus.video_on) begin
         pix_c = 3'd0;
         sel_c = 3'd7;
      end else begin
         for (int i = 3; i >= 0; i--) begin
            if (elig[i]) begin
               pix_c = active[i];
               sel_c = 3'(i);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vsync_q     <= 1'b1;
         active[0]   <= 3'd7;
         active[1]   <= 3'd4;
         active[2]   <= 3'd2;
         active[3]   <= 3'd1;
         shadow[0]   <= 3'd7;
         shadow[1]   <= 3'd4;
         shadow[2]   <= 3'd2;
         shadow[3]   <= 3'd1;
         bg          <= 3'd0;
         blink_cnt   <= 6'd0;
         blink_phase <= 1'b1;
         frame_q     <= '0;
         colores_q   <= 3'd0;
         layer_sel_q <= 3'd7;
         ack_q       <= 1'b0;
         pending_q   <= 1'b0;
      end else begin
         vsync_q <= bus.vsync;
         ack_q   <= bus.cfg_we;

         // Copy uses the pre-edge shadow, so a same-cycle write waits one more frame.
         if (commit) begin
            for (int i = 0; i < 4; i++) active[i] <= shadow[i];
            bg      <= {bus.r, bus.g, bus.b};
            frame_q <= frame_q + FRAME_W'(1);
            if (blink_cnt == 6'(BLINK_HALF - 1)) begin
               blink_cnt   <= 6'd0;
               blink_phase <= ~blink_phase;
            end else begin
               blink_cnt <= blink_cnt + 6'd1;
            end
         end

         if (bus.cfg_we) begin
            shadow[bus.cfg_addr] <= bus.cfg_data;
            pending_q            <= 1'b1;
         end else if (commit) begin
            pending_q <= 1'b0;
         end

         if (blank) begin
            colores_q   <= 3'd0;
            layer_sel_q <= 3'd7;
         end else if (bus.p_tick) begin
            colores_q   <= pix_c;
            layer_sel_q <= sel_c;
         end
      end
   end

   assign bus.colores     = colores_q;
   assign bus.layer_sel   = layer_sel_q;
   assign bus.cfg_ack     = ack_q;
   assign bus.cfg_pending = pending_q;
   assign bus.frame_cnt   = frame_q;

endmodule
